// File: rtl/scic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scic_pkg
// Description : Definitions shared by the SCIC CPU and its bus responder.
//               Holds the opcode map, the I/O page location and register
//               offsets, and the program-loader state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package scic_pkg;

  // Opcodes decoded by the SCIC CPU (bits [31:26] of an instruction word).
  localparam logic [5:0] C_OP_NOP   = 6'h00;
  localparam logic [5:0] C_OP_LOAD  = 6'h01;
  localparam logic [5:0] C_OP_STORE = 6'h02;
  localparam logic [5:0] C_OP_ADD   = 6'h03;
  localparam logic [5:0] C_OP_SUB   = 6'h04;
  localparam logic [5:0] C_OP_AND   = 6'h05;
  localparam logic [5:0] C_OP_OR    = 6'h06;
  localparam logic [5:0] C_OP_JUMP  = 6'h07;
  localparam logic [5:0] C_OP_BEQ   = 6'h08;
  localparam logic [5:0] C_OP_HALT  = 6'h3F;

  // Default base of the 16-word memory-mapped I/O page.
  localparam logic [15:0] C_MMIO_BASE = 16'hFFF0;

  // Register offsets inside the I/O page.
  localparam logic [3:0] C_MMIO_GPIO   = 4'd0;
  localparam logic [3:0] C_MMIO_CYCLE  = 4'd1;
  localparam logic [3:0] C_MMIO_STATUS = 4'd2;

  // Loader state encoding.
  typedef logic [1:0] ld_state_t;
  localparam ld_state_t ST_IDLE    = 2'd0;
  localparam ld_state_t ST_ACCUM   = 2'd1;
  localparam ld_state_t ST_WRITE   = 2'd2;
  localparam ld_state_t ST_RELEASE = 2'd3;

endpackage : scic_pkg
`default_nettype wire

// File: rtl/scic_byte_loader.sv
`default_nettype none
// ============================================================================
// Module      : scic_byte_loader
// Description : Byte-serial program loader. Packs incoming bytes big-endian
//               into 32-bit words and emits one RAM write strobe per word,
//               starting at word address 0. Reports busy while a session is
//               in progress so the CPU can be held in reset.
// Ports       : clock, reset (async, active-low)
//               ld_valid/ld_byte/ld_last/ld_ready - byte stream handshake
//               busy        - loader not idle (drives CPU hold)
//               wr_en/wr_addr/wr_data - RAM write request, one cycle per word
//               word_count  - words written in the current/last session
// Revision    : 1.0 - initial release
// ============================================================================
module scic_byte_loader
  import scic_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              busy,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [15:0]       word_count
);

  ld_state_t         r_state;
  logic [1:0]        r_byte_idx;
  logic [31:0]       r_word;
  logic [ADDR_W-1:0] r_load_addr;
  logic [15:0]       r_word_count;
  logic              r_last;

  logic              w_accept;
  logic [31:0]       w_word_next;

  // Ready is forced low while reset is held so nothing is handshaken then.
  assign ld_ready   = reset && ((r_state == ST_IDLE) || (r_state == ST_ACCUM));
  assign w_accept   = ld_valid && ld_ready;
  assign busy       = (r_state != ST_IDLE);
  assign wr_en      = (r_state == ST_WRITE);
  assign wr_addr    = r_load_addr;
  assign wr_data    = r_word;
  assign word_count = r_word_count;

  // The word register is cleared after every write, so lanes never filled
  // before ld_last stay zero.
  always_comb begin
    w_word_next = r_word;
    case (r_byte_idx)
      2'd0:    w_word_next[31:24] = ld_byte;
      2'd1:    w_word_next[23:16] = ld_byte;
      2'd2:    w_word_next[15:8]  = ld_byte;
      default: w_word_next[7:0]   = ld_byte;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_byte_idx   <= 2'd0;
      r_word       <= 32'd0;
      r_load_addr  <= '0;
      r_word_count <= 16'd0;
      r_last       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            // First byte of a session: restart address and count.
            r_word       <= {ld_byte, 24'd0};
            r_byte_idx   <= 2'd1;
            r_load_addr  <= '0;
            r_word_count <= 16'd0;
            r_last       <= ld_last;
            r_state      <= ld_last ? ST_WRITE : ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (w_accept) begin
            r_word     <= w_word_next;
            r_byte_idx <= r_byte_idx + 2'd1;
            r_last     <= ld_last;
            if (ld_last || (r_byte_idx == 2'd3)) begin
              r_state <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          r_load_addr <= r_load_addr + ADDR_W'(1);
          if (r_word_count != 16'hFFFF) begin
            r_word_count <= r_word_count + 16'd1;
          end
          r_byte_idx <= 2'd0;
          r_word     <= 32'd0;
          r_state    <= r_last ? ST_RELEASE : ST_ACCUM;
        end
        ST_RELEASE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : scic_byte_loader
`default_nettype wire

// File: rtl/scic_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : scic_bus_responder
// Description : Memory-side responder for the SCIC CPU bus. Provides a
//               word-addressed data RAM with combinational read, a 16-word
//               I/O page (GPIO, cycle counter, status) and a byte-serial
//               program loader that holds the CPU in reset while it fills RAM.
// Ports       : clock, reset (async, active-low)
//               address/we/data_in/data_out - CPU bus
//               ld_valid/ld_byte/ld_last/ld_ready - loader byte stream
//               cpu_hold - CPU reset request, high while loading
//               gpio_out - general-purpose output register
// Revision    : 1.0 - initial release
// ============================================================================
module scic_bus_responder #(
  parameter int          ADDR_W    = 10,
  parameter logic [15:0] MMIO_BASE = scic_pkg::C_MMIO_BASE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic        we,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  input  logic        ld_valid,
  input  logic [7:0]  ld_byte,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        cpu_hold,
  output logic [31:0] gpio_out
);

  import scic_pkg::*;

  localparam int DEPTH = 2 ** ADDR_W;

  logic [31:0]       r_mem [DEPTH];
  logic [31:0]       r_gpio;
  logic [31:0]       r_cycle;

  logic              w_ram_sel;
  logic              w_mmio_sel;
  logic [15:0]       w_mmio_off;
  logic [ADDR_W-1:0] w_ram_idx;
  logic              w_cpu_ram_wr;
  logic              w_gpio_wr;
  logic              w_cycle_wr;

  logic              w_ld_busy;
  logic              w_ld_wr;
  logic [ADDR_W-1:0] w_ld_addr;
  logic [31:0]       w_ld_data;
  logic [15:0]       w_ld_count;

  scic_byte_loader #(
    .ADDR_W (ADDR_W)
  ) u_loader (
    .clock      (clock),
    .reset      (reset),
    .ld_valid   (ld_valid),
    .ld_byte    (ld_byte),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .busy       (w_ld_busy),
    .wr_en      (w_ld_wr),
    .wr_addr    (w_ld_addr),
    .wr_data    (w_ld_data),
    .word_count (w_ld_count)
  );

  assign cpu_hold = w_ld_busy;
  assign gpio_out = r_gpio;

  // Address decode. The RAM test is done in 32 bits so ADDR_W up to 16
  // works. If the RAM ever grows into the I/O page, RAM takes precedence.
  assign w_ram_sel  = ({16'd0, address} < (32'd1 << ADDR_W));
  assign w_ram_idx  = address[ADDR_W-1:0];
  assign w_mmio_off = address - MMIO_BASE;
  assign w_mmio_sel = !w_ram_sel && (w_mmio_off < 16'd16);

  assign w_cpu_ram_wr = we && w_ram_sel;
  assign w_gpio_wr    = we && w_mmio_sel && (w_mmio_off[3:0] == C_MMIO_GPIO);
  assign w_cycle_wr   = we && w_mmio_sel && (w_mmio_off[3:0] == C_MMIO_CYCLE);

  // Single write port: a loader word always beats a CPU write in the same
  // cycle. RAM contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (w_ld_wr) begin
      r_mem[w_ld_addr] <= w_ld_data;
    end else if (w_cpu_ram_wr) begin
      r_mem[w_ram_idx] <= data_in;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_gpio <= 32'd0;
    end else if (w_gpio_wr) begin
      r_gpio <= data_in;
    end
  end

  // Any write to CYCLE zeroes it on that edge instead of incrementing.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cycle <= 32'd0;
    end else if (w_cycle_wr) begin
      r_cycle <= 32'd0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
    end
  end

  always_comb begin
    data_out = 32'd0;
    if (w_ram_sel) begin
      data_out = r_mem[w_ram_idx];
    end else if (w_mmio_sel) begin
      case (w_mmio_off[3:0])
        C_MMIO_GPIO:   data_out = r_gpio;
        C_MMIO_CYCLE:  data_out = r_cycle;
        C_MMIO_STATUS: data_out = {w_ld_busy, 15'd0, w_ld_count};
        default:       data_out = 32'd0;
      endcase
    end
  end

endmodule : scic_bus_responder
`default_nettype wire

// File: tb/tb_scic_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_scic_bus_responder
// Description : Scoreboard bench for scic_bus_responder. One instance with
//               the default RAM size, one with ADDR_W=2 for address wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scic_bus_responder;

  localparam int K_DOUT   = 0;
  localparam int K_GPIO   = 1;
  localparam int K_HOLD   = 2;
  localparam int K_READY  = 3;
  localparam int K_DOUT2  = 4;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } item_t;

  item_t sb[$];
  int    checks = 0;
  int    errors = 0;

  logic        clock = 1'b0;
  logic        reset = 1'b0;

  logic [15:0] address  = '0;
  logic        we       = 1'b0;
  logic [31:0] data_in  = '0;
  logic [31:0] data_out;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_byte  = '0;
  logic        ld_last  = 1'b0;
  logic        ld_ready;
  logic        cpu_hold;
  logic [31:0] gpio_out;

  logic [15:0] address2  = '0;
  logic        we2       = 1'b0;
  logic [31:0] data_in2  = '0;
  logic [31:0] data_out2;
  logic        ld_valid2 = 1'b0;
  logic [7:0]  ld_byte2  = '0;
  logic        ld_last2  = 1'b0;
  logic        ld_ready2;
  logic        cpu_hold2;
  logic [31:0] gpio_out2;

  always #5 clock = ~clock;

  scic_bus_responder dut (
    .clock    (clock),
    .reset    (reset),
    .address  (address),
    .we       (we),
    .data_in  (data_in),
    .data_out (data_out),
    .ld_valid (ld_valid),
    .ld_byte  (ld_byte),
    .ld_last  (ld_last),
    .ld_ready (ld_ready),
    .cpu_hold (cpu_hold),
    .gpio_out (gpio_out)
  );

  scic_bus_responder #(.ADDR_W(2)) dut2 (
    .clock    (clock),
    .reset    (reset),
    .address  (address2),
    .we       (we2),
    .data_in  (data_in2),
    .data_out (data_out2),
    .ld_valid (ld_valid2),
    .ld_byte  (ld_byte2),
    .ld_last  (ld_last2),
    .ld_ready (ld_ready2),
    .cpu_hold (cpu_hold2),
    .gpio_out (gpio_out2)
  );

  // Monitor: every expectation queued during a cycle is compared at the
  // following falling edge, well away from the active edge.
  always @(negedge clock) begin
    item_t       it;
    logic [31:0] act;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      case (it.kind)
        K_DOUT:  act = data_out;
        K_GPIO:  act = gpio_out;
        K_HOLD:  act = {31'd0, cpu_hold};
        K_READY: act = {31'd0, ld_ready};
        default: act = data_out2;
      endcase
      checks++;
      if (act !== it.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_val(input int kind, input logic [31:0] exp, input string name);
    item_t it;
    it.kind = kind;
    it.exp  = exp;
    it.name = name;
    sb.push_back(it);
  endtask

  task automatic chk_read(input int sel, input logic [15:0] addr,
                          input logic [31:0] exp, input string name);
    if (sel == 0) address = addr;
    else          address2 = addr;
    expect_val((sel == 0) ? K_DOUT : K_DOUT2, exp, name);
    tick();
  endtask

  task automatic send_byte(input int sel, input logic [7:0] b, input logic last);
    int n = 0;
    if (sel == 0) begin ld_valid = 1'b1; ld_byte = b; ld_last = last; end
    else begin ld_valid2 = 1'b1; ld_byte2 = b; ld_last2 = last; end
    while (!((sel == 0) ? ld_ready : ld_ready2) && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL ld_ready_timeout: got 0 expected 1 within 20 cycles");
    end
    tick();
    if (sel == 0) begin ld_valid = 1'b0; ld_last = 1'b0; end
    else begin ld_valid2 = 1'b0; ld_last2 = 1'b0; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    expect_val(K_HOLD,  32'd0, "rst_cpu_hold");
    expect_val(K_READY, 32'd0, "rst_ld_ready");
    expect_val(K_GPIO,  32'd0, "rst_gpio");
    tick();
    tick();
    reset = 1'b1;
    expect_val(K_READY, 32'd1, "idle_ld_ready");
    tick();
    chk_read(0, 16'hFFF2, 32'd0, "rst_status");

    // CPU RAM write and zero-latency read
    address = 16'd5; we = 1'b1; data_in = 32'hDEADBEEF;
    tick();
    we = 1'b0;
    chk_read(0, 16'd5,     32'hDEADBEEF, "ram_rd_5");
    chk_read(0, 16'h8000,  32'd0,        "unmapped_rd");

    // Eight-byte load
    send_byte(0, 8'h01, 1'b0);
    expect_val(K_HOLD, 32'd1, "hold_after_first");
    for (int i = 2; i <= 8; i++) send_byte(0, 8'(i), (i == 8));
    expect_val(K_READY, 32'd0, "l1_write_ready");
    expect_val(K_HOLD,  32'd1, "l1_write_hold");
    tick();
    expect_val(K_READY, 32'd0, "l1_release_ready");
    expect_val(K_HOLD,  32'd1, "l1_release_hold");
    tick();
    expect_val(K_HOLD,  32'd0, "l1_idle_hold");
    chk_read(0, 16'd0,     32'h01020304, "l1_mem0");
    chk_read(0, 16'd1,     32'h05060708, "l1_mem1");
    chk_read(0, 16'hFFF2,  32'd2,        "l1_status");

    // Six-byte load with partial last word; CPU write collides with WRITE
    send_byte(0, 8'hAA, 1'b0);
    send_byte(0, 8'hBB, 1'b0);
    send_byte(0, 8'hCC, 1'b0);
    send_byte(0, 8'hDD, 1'b0);
    expect_val(K_READY, 32'd0, "l2_write_ready");
    address = 16'd0; we = 1'b1; data_in = 32'hCAFEF00D;
    tick();
    we = 1'b0;
    send_byte(0, 8'hEE, 1'b0);
    send_byte(0, 8'hFF, 1'b1);
    expect_val(K_READY, 32'd0, "l2_write2_ready");
    tick();
    address = 16'hFFF2;
    expect_val(K_READY, 32'd0,          "l2_release_ready");
    expect_val(K_DOUT,  32'h80000002,   "l2_status_busy");
    tick();
    chk_read(0, 16'd0,    32'hAABBCCDD, "l2_mem0_loader_wins");
    chk_read(0, 16'd1,    32'hEEFF0000, "l2_mem1_partial");
    chk_read(0, 16'hFFF2, 32'd2,        "l2_status");

    // GPIO and cycle counter
    address = 16'hFFF0; we = 1'b1; data_in = 32'h5A;
    expect_val(K_GPIO, 32'd0, "gpio_before_edge");
    tick();
    we = 1'b0;
    expect_val(K_GPIO, 32'h5A, "gpio_after_edge");
    chk_read(0, 16'hFFF0, 32'h5A, "gpio_rd");
    address = 16'hFFF1; we = 1'b1; data_in = 32'h1234;
    tick();
    we = 1'b0;
    chk_read(0, 16'hFFF1, 32'd0, "cycle_cleared");
    tick();
    tick();
    chk_read(0, 16'hFFF1, 32'd3, "cycle_plus3");

    // Reset in the middle of a load
    for (int i = 0; i < 6; i++) send_byte(0, 8'h11 + 8'(i), 1'b0);
    reset = 1'b0;
    expect_val(K_HOLD,  32'd0, "midrst_hold");
    expect_val(K_READY, 32'd0, "midrst_ready");
    tick();
    reset = 1'b1;
    chk_read(0, 16'hFFF2, 32'd0,        "midrst_status");
    chk_read(0, 16'd0,    32'h11121314, "midrst_mem0_kept");
    for (int i = 0; i < 4; i++) send_byte(0, 8'h21 + 8'(i), (i == 3));
    tick();
    tick();
    chk_read(0, 16'd0,    32'h21222324, "reload_mem0");
    chk_read(0, 16'd1,    32'hEEFF0000, "reload_no_extra_word");
    chk_read(0, 16'hFFF2, 32'd1,        "reload_status");

    // ADDR_W=2 wrap
    for (int i = 0; i < 20; i++) send_byte(1, 8'h40 + 8'(i), (i == 19));
    tick();
    tick();
    chk_read(1, 16'd0,    32'h50515253, "wrap_mem0");
    chk_read(1, 16'd1,    32'h44454647, "wrap_mem1");
    chk_read(1, 16'd3,    32'h4C4D4E4F, "wrap_mem3");
    chk_read(1, 16'd4,    32'd0,        "wrap_out_of_range");
    chk_read(1, 16'hFFF2, 32'd5,        "wrap_status");

    tick();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_scic_bus_responder
`default_nettype wire

// File: doc/scic_bus_responder.md
Name: scic_bus_responder

Overview:
- Memory-side responder for the SCIC CPU bus (16-bit word address, 32-bit data, single write-enable, combinational read).
- Provides data RAM, a memory-mapped I/O page and a byte-serial program loader.
- While the loader fills RAM it holds the CPU in reset, then releases it so the CPU starts fetching at PC=0.

Parameters:
- ADDR_W, 10, RAM word-address width; RAM depth = 2^ADDR_W 32-bit words.
- MMIO_BASE, 16'hFFF0, first address of the 16-word I/O page.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (reset=0 clears state immediately).
- address  in  16  word address from the CPU.
- we  in  1  CPU write enable; the write commits on the rising edge.
- data_in  in  32  write data from the CPU.
- data_out  out  32  read data to the CPU; combinational from address.
- ld_valid  in  1  loader byte valid.
- ld_byte  in  8  loader byte.
- ld_last  in  1  marks the final byte of the image; qualified by ld_valid.
- ld_ready  out  1  loader can accept a byte this cycle.
- cpu_hold  out  1  drive to the CPU reset; high while loading.
- gpio_out  out  32  general-purpose output register.

Behaviour:
- Reset values:
  - cpu_hold=0, ld_ready=0 while reset=0, gpio_out=0.
  - Cycle counter=0, loader in IDLE, load address=0, byte index=0, word count=0.
  - RAM contents are not reset.
- Address decode:
  - address < 2^ADDR_W: RAM.
  - MMIO_BASE..MMIO_BASE+15: I/O page.
  - Any other address reads 0; writes to it are ignored.
- RAM read is combinational: data_out = mem[address] in the same cycle.
  - The CPU samples data_out at its own edge, so read latency is 0 cycles.
- RAM write: when we=1 and address is in range, mem[address] <= data_in at the edge.
- MMIO page (offset from MMIO_BASE):
  - 0: GPIO, read/write; a write updates gpio_out at the next edge.
  - 1: CYCLE, a 32-bit free-running counter, +1 per clock, wraps at 2^32. A write of any value clears it to 0 at that edge (the counter does not increment on that edge).
  - 2: STATUS, read-only: bit31 = loader busy (state != IDLE); bits[15:0] = words written in the last load session.
  - Offsets 3-15: read 0, writes ignored.
- Loader FSM:
  - IDLE
    - ld_ready=1, cpu_hold=0.
    - ld_valid=1 accepts the byte as byte 0 of the word, clears load address and word count, and moves to ACCUM.
    - cpu_hold=1 from the next cycle.
  - ACCUM
    - ld_ready=1, cpu_hold=1.
    - Each accepted byte fills the word big-endian: byte0 -> [31:24] ... byte3 -> [7:0].
    - After the 4th byte, or on any byte with ld_last=1, go to WRITE.
    - On ld_last with a partial word, the unfilled low bytes are 0.
  - WRITE
    - ld_ready=0, one cycle.
    - mem[load_addr] <= assembled word; load_addr += 1 (wraps to 0 at 2^ADDR_W); word count += 1 (saturates at 16'hFFFF).
    - Byte index clears.
    - Next state is RELEASE if the word ended with ld_last, otherwise ACCUM.
  - RELEASE
    - ld_ready=0, cpu_hold=1, one cycle; then IDLE.
    - cpu_hold falls on the IDLE entry edge.
  - A byte is accepted only when ld_valid && ld_ready at the edge.
- Simultaneous events:
  - If a CPU write and a loader write target the same cycle, the loader wins; the CPU write is dropped.
  - CPU writes are already moot while cpu_hold=1.
- Reset mid-load: the FSM returns to IDLE and cpu_hold drops.
  - The partial word is discarded; RAM words already written are kept.
  - Word count clears.
- ld_last on the 4th byte produces exactly one WRITE, with no extra zero word.

Decomposition:
- Shared package scic_pkg holds:
  - Opcode constants shared with the CPU.
  - MMIO_BASE and the MMIO offset constants (GPIO=0, CYCLE=1, STATUS=2).
  - The loader state enum.
- One natural sub-module: scic_byte_loader (FSM, byte assembly, load address, word count). It emits a write strobe, address and data to the top, which owns the RAM, the MMIO and the write arbitration.

Test Plan:
- Reset, then CPU writes 32'hDEADBEEF to address 5 and reads address 5 -> data_out=32'hDEADBEEF the same cycle; a read of address 16'h8000 returns 0.
- Load 8 bytes 01..08, last with ld_last -> mem[0]=32'h01020304 and mem[1]=32'h05060708; cpu_hold high from the cycle after the first byte until the IDLE edge; STATUS[15:0]=2 and bit31=0 afterwards.
- Load 6 bytes AA,BB,CC,DD,EE,FF with ld_last on FF -> mem[1]=32'hEEFF0000; ld_ready=0 during WRITE and RELEASE.
- CPU writes 32'h5A to GPIO -> gpio_out=32'h5A after the edge; write to CYCLE -> reads 0 the next cycle, 3 three cycles later.
- Assert reset low after 6 bytes of a load -> cpu_hold=0 immediately; mem[0] keeps the first word; the next load restarts at address 0.
- ADDR_W=2: load 5 full words -> the 5th word wraps and overwrites mem[0]; STATUS[15:0]=5.
